// File: rtl/mem_line_resp.sv
// rtl/mem_line_resp.sv - I/D line refill/writeback responder over a word-addressed backing store
// Optional feature: define MEM_RESP_RR_ARB_EN for round-robin arbitration (default: D side wins ties).
module mem_line_resp #(
  parameter int MEM_WORDS = 16384,
  parameter int RD_LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_rvld,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_wrdy,
  output logic        d_rvld,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_done,
  output logic        d_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 4;

  typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, DONE} state_t;

  logic [31:0]   mem [MEM_WORDS];

  state_t        state, state_n;
  logic [3:0]    lat_cnt, lat_cnt_n;
  logic [3:0]    beat, beat_n;
  logic [LW-1:0] line, line_n;
  logic          side, side_n;       // 0 = I side, 1 = D side
  logic          we_q, we_n;
  logic          last_d, last_d_n;   // last grant went to D side
  logic          i_ack_q, i_ack_n, d_ack_q, d_ack_n;
  logic          i_err_q, i_err_n, d_err_q, d_err_n;

  logic          i_pend, d_pend, can_grant, pick_d, grant, sel_we, oor;
  logic [31:0]   sel_addr;
  logic [AW-1:0] mem_idx;
  logic [31:0]   word;
  logic          unused_bits;

  // A request seen in its own ack cycle is the one just served, so mask it out.
  assign i_pend = i_req & ~i_ack_q;
  assign d_pend = d_req & ~d_ack_q;

`ifdef MEM_RESP_RR_ARB_EN
  assign pick_d      = d_pend & (~i_pend | ~last_d);
  assign unused_bits = ^sel_addr[5:0];
`else
  assign pick_d      = d_pend;
  assign unused_bits = ^{sel_addr[5:0], last_d};
`endif

  // Grants are taken in IDLE and also in the final cycle of a burst / done pulse,
  // so a waiting requester is acked in the very next cycle.
  assign can_grant = (state == IDLE) || (state == DONE) ||
                     ((state == RD_BURST) && (beat == 4'd15));
  assign grant     = can_grant & (i_pend | d_pend);
  assign sel_addr  = pick_d ? d_addr : i_addr;
  assign sel_we    = pick_d & d_we;
  assign oor       = {2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS);

  assign mem_idx   = {line, beat};
  assign word      = mem[mem_idx];

  // Next-state, counters, grant bookkeeping
  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    beat_n    = beat;
    line_n    = line;
    side_n    = side;
    we_n      = we_q;
    last_d_n  = last_d;
    i_ack_n   = 1'b0;
    d_ack_n   = 1'b0;
    i_err_n   = 1'b0;
    d_err_n   = 1'b0;

    case (state)
      IDLE: ;
      LAT: begin
        if (lat_cnt == 4'd0) begin
          state_n = we_q ? WR_BURST : RD_BURST;
          beat_n  = 4'd0;
        end else begin
          lat_cnt_n = lat_cnt - 4'd1;
        end
      end
      RD_BURST: begin
        if (beat == 4'd15) state_n = IDLE;
        else               beat_n  = beat + 4'd1;
      end
      WR_BURST: begin
        if (beat == 4'd15) state_n = DONE;
        else               beat_n  = beat + 4'd1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (grant) begin
      i_ack_n  = ~pick_d;
      d_ack_n  = pick_d;
      last_d_n = pick_d;
      if (oor) begin
        i_err_n = ~pick_d;
        d_err_n = pick_d;
        state_n = IDLE;
      end else begin
        state_n   = LAT;
        lat_cnt_n = sel_we ? 4'd0 : 4'(RD_LAT - 1);
        line_n    = sel_addr[AW+1:6];
        side_n    = pick_d;
        we_n      = sel_we;
      end
    end
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
      beat    <= 4'd0;
      line    <= '0;
      side    <= 1'b0;
      we_q    <= 1'b0;
      last_d  <= 1'b1;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      beat    <= beat_n;
      line    <= line_n;
      side    <= side_n;
      we_q    <= we_n;
      last_d  <= last_d_n;
      i_ack_q <= i_ack_n;
      d_ack_q <= d_ack_n;
      i_err_q <= i_err_n;
      d_err_q <= d_err_n;
    end
  end

  // Backing store write port; contents survive reset, an aborted beat is not written
  always_ff @(posedge clk) begin
    if (!rst && (state == WR_BURST)) mem[mem_idx] <= d_wdata;
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_err   = i_err_q;
  assign d_err   = d_err_q;
  assign i_rvld  = (state == RD_BURST) & ~side;
  assign d_rvld  = (state == RD_BURST) & side;
  assign i_rlast = i_rvld & (beat == 4'd15);
  assign d_rlast = d_rvld & (beat == 4'd15);
  assign i_rdata = i_rvld ? word : 32'd0;
  assign d_rdata = d_rvld ? word : 32'd0;
  assign d_wrdy  = (state == WR_BURST);
  assign d_done  = (state == DONE);

endmodule

// File: tb/tb_mem_line_resp.sv
// tb/tb_mem_line_resp.sv - scoreboard bench for mem_line_resp
module tb_mem_line_resp;
  localparam int MEM_WORDS = 16384;
  localparam int RD_LAT    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_rvld, i_rlast, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack, d_wrdy, d_rvld, d_rlast, d_done, d_err;
  logic [31:0] d_rdata;

  always #5 clk = ~clk;

  mem_line_resp #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvld(i_rvld),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_wrdy(d_wrdy), .d_rvld(d_rvld), .d_rdata(d_rdata),
    .d_rlast(d_rlast), .d_done(d_done), .d_err(d_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit d; bit we; bit err;} ack_t;
  typedef struct {logic [31:0] data; bit last; int k;} beat_t;

  ack_t        exp_ack[$];
  beat_t       exp_ib[$];
  beat_t       exp_db[$];
  bit          exp_done[$];
  logic [31:0] model [0:255];

  int total = 0;
  int bad = 0;
  int to_cnt = 0;
  bit stim_done = 1'b0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  int    ack_cyc_i = 0;
  int    ack_cyc_d = 0;
  int    wr_left = 0;
  int    wr_k = 0;
  bit    rst_prev = 1'b0;
  ack_t  ea;
  beat_t eb;
  bit    ed;

  // Sample every output at the falling edge and score it against the queues
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("reset_outputs_zero",
          {i_ack, i_rvld, i_rdata, i_rlast, i_err, d_ack, d_wrdy, d_rvld, d_rdata, d_rlast, d_done, d_err},
          96'd0);
      exp_ib.delete();
      exp_db.delete();
      wr_left = 0;
    end else begin
      if (i_ack || d_ack) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", {i_ack, d_ack}, 96'd0);
        else begin
          ea = exp_ack.pop_front();
          chk("ack_side_err", {i_ack, d_ack, i_err, d_err},
              {~ea.d, ea.d, ~ea.d & ea.err, ea.d & ea.err});
          if (i_ack) ack_cyc_i = cyc;
          if (d_ack) ack_cyc_d = cyc;
          if (ea.d && ea.we && !ea.err) begin
            wr_left = 16;
            wr_k = 0;
          end
        end
      end else if (i_err || d_err) begin
        chk("err_without_ack", {i_err, d_err}, 96'd0);
      end
      if (i_rvld && d_rvld) chk("both_rvld", 96'd1, 96'd0);
      if (i_rvld) begin
        if (exp_ib.size() == 0) chk("unexpected_i_beat", {i_rdata, i_rlast}, 96'd0);
        else begin
          eb = exp_ib.pop_front();
          chk("i_beat_data_last", {i_rdata, i_rlast}, {eb.data, eb.last});
          chk("i_beat_timing", cyc - ack_cyc_i, RD_LAT + eb.k);
        end
      end
      if (d_rvld) begin
        if (exp_db.size() == 0) chk("unexpected_d_beat", {d_rdata, d_rlast}, 96'd0);
        else begin
          eb = exp_db.pop_front();
          chk("d_beat_data_last", {d_rdata, d_rlast}, {eb.data, eb.last});
          chk("d_beat_timing", cyc - ack_cyc_d, RD_LAT + eb.k);
        end
      end
      if (d_wrdy) begin
        if (wr_left == 0) chk("unexpected_wrdy", 96'd1, 96'd0);
        else begin
          chk("wrdy_timing", cyc - ack_cyc_d, wr_k + 1);
          wr_k++;
          wr_left--;
        end
      end
      if (d_done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 96'd1, 96'd0);
        else begin
          ed = exp_done.pop_front();
          chk("done_timing", cyc - ack_cyc_d, 17);
        end
      end
    end
    rst_prev = rst;

    if (stim_done || cyc > 20000) begin
      chk("not_timed_out", cyc > 20000, 96'd0);
      chk("acks_left", exp_ack.size(), 96'd0);
      chk("i_beats_left", exp_ib.size(), 96'd0);
      chk("d_beats_left", exp_db.size(), 96'd0);
      chk("dones_left", exp_done.size(), 96'd0);
      chk("wait_timeouts", to_cnt, 96'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input bit d, input logic [31:0] addr);
    int w;
    beat_t b;
    w = int'((addr >> 2) & 32'hFFFF_FFF0);
    for (int k = 0; k < 16; k++) begin
      b.data = model[w + k];
      b.last = (k == 15);
      b.k    = k;
      if (d) exp_db.push_back(b);
      else   exp_ib.push_back(b);
    end
  endtask

  task automatic wait_ack(input bit d);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (d ? d_ack : i_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
    if (d) d_req = 1'b0;
    else   i_req = 1'b0;
  endtask

  task automatic wait_last(input bit d);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (d ? d_rlast : i_rlast) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
  endtask

  task automatic rd_line(input bit d, input logic [31:0] addr);
    exp_ack.push_back('{d: d, we: 1'b0, err: 1'b0});
    push_read(d, addr);
    if (d) begin d_req = 1'b1; d_we = 1'b0; d_addr = addr; end
    else   begin i_req = 1'b1; i_addr = addr; end
    wait_ack(d);
    wait_last(d);
  endtask

  task automatic wr_line(input logic [31:0] addr, input logic [31:0] pat);
    int w;
    int k;
    bit got;
    w = int'((addr >> 2) & 32'hFFFF_FFF0);
    exp_ack.push_back('{d: 1'b1, we: 1'b1, err: 1'b0});
    exp_done.push_back(1'b1);
    d_req = 1'b1; d_we = 1'b1; d_addr = addr;
    wait_ack(1'b1);
    k = 0;
    for (int n = 0; n < 40 && k < 16; n++) begin
      tick();
      if (d_wrdy) begin
        d_wdata = pat + 32'(k);
        model[w + k] = pat + 32'(k);
        k++;
      end
    end
    if (k < 16) to_cnt++;
    got = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (d_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
  endtask

  task automatic err_req(input bit d, input logic [31:0] addr);
    exp_ack.push_back('{d: d, we: d, err: 1'b1});
    if (d) begin d_req = 1'b1; d_we = 1'b1; d_addr = addr; end
    else   begin i_req = 1'b1; i_addr = addr; end
    wait_ack(d);
    repeat (4) tick();
  endtask

  task automatic both_round();
    bit first_d;
    bit got;
`ifdef MEM_RESP_RR_ARB_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    exp_ack.push_back('{d: first_d, we: 1'b0, err: 1'b0});
    push_read(first_d, first_d ? 32'h40 : 32'h100);
    exp_ack.push_back('{d: ~first_d, we: 1'b0, err: 1'b0});
    push_read(~first_d, first_d ? 32'h100 : 32'h40);
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    got = 1'b0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (i_ack) i_req = 1'b0;
      if (d_ack) d_req = 1'b0;
      if (!i_req && !d_req && exp_ib.size() == 0 && exp_db.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    wr_line(32'h100, 32'h100);      // preload words 64..79 = 0x100+k
    rd_line(1'b0, 32'h100);         // I refill 0x100..0x10F
    wr_line(32'h40, 32'hA0);        // writeback 0xA0+k
    rd_line(1'b1, 32'h40);          // D read back 0xA0..0xAF
    rd_line(1'b0, 32'h13C);         // low address bits ignored
    err_req(1'b1, 32'(MEM_WORDS * 4));
    err_req(1'b0, 32'hFFFF_FFC0);

    // reset while beat 7 of an I refill is on the bus
    exp_ack.push_back('{d: 1'b0, we: 1'b0, err: 1'b0});
    push_read(1'b0, 32'h100);
    i_req = 1'b1; i_addr = 32'h100;
    wait_ack(1'b0);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rd_line(1'b0, 32'h100);

    // simultaneous requests from a fresh arbitration pointer
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    both_round();
    both_round();

    repeat (3) tick();
    stim_done = 1'b1;
    repeat (3) tick();
  end
endmodule
